// File: rtl/w_tile_wr_ctrl.sv
// Weight-tile write controller: streams weight rows into SYS_COL banks, one row per
// bank address, tile after tile, with optional reversed row order inside each tile.
module w_tile_wr_ctrl #(
    parameter int SYS_ROW        = 16,
    parameter int SYS_COL        = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TILE_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cfg_start,
    input  logic [ADDR_WIDTH-1:0]         cfg_base_addr,
    input  logic [TILE_CNT_WIDTH-1:0]     cfg_num_tiles,
    input  logic                          cfg_rev,
    input  logic [SYS_COL-1:0]            cfg_col_mask,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SYS_COL*DATA_WIDTH-1:0] in_data,
    output logic [SYS_COL-1:0]            wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [SYS_COL*DATA_WIDTH-1:0] wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int ROW_W  = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1;
    localparam int CALC_W = ADDR_WIDTH + TILE_CNT_WIDTH;
    localparam int DW     = SYS_COL * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [TILE_CNT_WIDTH-1:0] tile_q, tile_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [TILE_CNT_WIDTH-1:0] num_tiles_q, num_tiles_d;
    logic                      rev_q, rev_d;
    logic [SYS_COL-1:0]        mask_q, mask_d;
    logic [SYS_COL-1:0]        wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]             wr_data_q, wr_data_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                      xfer;
    logic                      last_row;
    logic                      last_tile;
    logic [CALC_W-1:0]         row_off;
    logic [CALC_W-1:0]         addr_calc;

    // Address math is done wide and truncated so that base + tile offset wraps cleanly.
    always_comb begin
        xfer      = in_valid && in_ready_q;
        last_row  = (row_q == ROW_W'(SYS_ROW - 1));
        last_tile = (tile_q == (num_tiles_q - TILE_CNT_WIDTH'(1)));
        row_off   = rev_q ? (CALC_W'(SYS_ROW - 1) - CALC_W'(row_q)) : CALC_W'(row_q);
        addr_calc = CALC_W'(base_q) + (CALC_W'(tile_q) * CALC_W'(SYS_ROW)) + row_off;
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        tile_d      = tile_q;
        base_d      = base_q;
        num_tiles_d = num_tiles_q;
        rev_d       = rev_q;
        mask_d      = mask_q;
        wr_en_d     = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_num_tiles != '0) begin
                        state_d     = LOAD;
                        row_d       = '0;
                        tile_d      = '0;
                        base_d      = cfg_base_addr;
                        num_tiles_d = cfg_num_tiles;
                        rev_d       = cfg_rev;
                        mask_d      = cfg_col_mask;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b1;
                        err_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Rows offered while idle are dropped; flagging wins over a same-cycle clear.
                if (in_valid) begin
                    err_d = 1'b1;
                end
            end

            LOAD: begin
                if (cfg_start) begin
                    err_d = 1'b1;
                end
                if (xfer) begin
                    wr_en_d   = mask_q;
                    wr_addr_d = addr_calc[ADDR_WIDTH-1:0];
                    wr_data_d = in_data;
                    if (last_row) begin
                        row_d  = '0;
                        tile_d = tile_q + TILE_CNT_WIDTH'(1);
                        if (last_tile) begin
                            state_d    = DONE;
                            in_ready_d = 1'b0;
                            done_d     = 1'b1;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end

            DONE: begin
                if (cfg_start) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            row_q       <= '0;
            tile_q      <= '0;
            base_q      <= '0;
            num_tiles_q <= '0;
            rev_q       <= 1'b0;
            mask_q      <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            tile_q      <= tile_d;
            base_q      <= base_d;
            num_tiles_q <= num_tiles_d;
            rev_q       <= rev_d;
            mask_q      <= mask_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/w_tile_wr_ctrl.md
W_TILE_WR_CTRL -- requirements
Module: w_tile_wr_ctrl

Interface
REQ-001 SHALL have parameter SYS_ROW, default 16, meaning rows per weight tile.
REQ-002 SHALL have parameter SYS_COL, default 16, meaning write columns (memory banks).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning bits per weight element.
REQ-004 SHALL have parameter ADDR_WIDTH, default 16, meaning bank address width.
REQ-005 SHALL have parameter TILE_CNT_WIDTH, default 8, meaning width of the tile count field.
REQ-006 SHALL have port clk, input, 1, meaning clock; all logic on rising edge.
REQ-007 SHALL have port rstn, input, 1, meaning reset, synchronous, active-low.
REQ-008 SHALL have port cfg_start, input, 1, meaning one-cycle pulse that latches the cfg_* fields and starts a load.
REQ-009 SHALL have port cfg_base_addr, input, ADDR_WIDTH, meaning first bank address of the load.
REQ-010 SHALL have port cfg_num_tiles, input, TILE_CNT_WIDTH, meaning number of tiles to load; 0 is illegal.
REQ-011 SHALL have port cfg_rev, input, 1, meaning 1 selects reversed row order in a tile, 0 selects forward order.
REQ-012 SHALL have port cfg_col_mask, input, SYS_COL, meaning per-column write enable mask.
REQ-013 SHALL have port in_valid, input, 1, meaning in_data holds one weight row.
REQ-014 SHALL have port in_ready, output, 1, meaning the block accepts a row this cycle.
REQ-015 SHALL have port in_data, input, SYS_COL x DATA_WIDTH, meaning one weight row.
REQ-016 SHALL have port wr_en, output, SYS_COL, meaning per-bank write strobe.
REQ-017 SHALL have port wr_addr, output, ADDR_WIDTH, meaning the address shared by all banks.
REQ-018 SHALL have port wr_data, output, SYS_COL x DATA_WIDTH, meaning per-bank write data.
REQ-019 SHALL have port busy, output, 1, meaning a load is in progress.
REQ-020 SHALL have port done, output, 1, meaning a one-cycle pulse at load completion.
REQ-021 SHALL have port err, output, 1, meaning a sticky error flag, cleared by cfg_start or reset.

Function
REQ-022 SHALL implement the states IDLE, LOAD and DONE.
REQ-023 SHALL move IDLE->LOAD on cfg_start with cfg_num_tiles!=0, latching all cfg_* fields and clearing the row and tile counters.
REQ-024 SHALL, on cfg_start with cfg_num_tiles==0, stay in IDLE, set err, and pulse no done.
REQ-025 SHALL drive in_ready=1 only in LOAD; a row transfer occurs on in_valid&&in_ready.
REQ-026 SHALL, per transfer, compute wr_addr = base + tile*SYS_ROW + (rev ? SYS_ROW-1-row : row), truncated modulo 2^ADDR_WIDTH.
REQ-027 SHALL, per transfer, set wr_en = latched mask and wr_data = in_data, registered so the write appears exactly 1 cycle after the transfer.
REQ-028 SHALL drive wr_en=0 in every cycle without a transfer, and SHALL hold wr_addr and wr_data at their last values.
REQ-029 SHALL increment row on each transfer; at row==SYS_ROW-1, row SHALL wrap to 0 and tile SHALL increment.
REQ-030 SHALL, on the transfer of the last row of tile cfg_num_tiles-1, move to DONE on the next edge, and in_ready SHALL be 0 from that edge on.
REQ-031 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE; the final write strobe and done SHALL be asserted in the same cycle.
REQ-032 SHALL hold counters unchanged while in_valid=0 in LOAD; stalls of any length are legal.
REQ-033 SHALL ignore cfg_start while in LOAD or DONE and set err.
REQ-034 SHALL set err on in_valid=1 while IDLE; the data is dropped and no write occurs.
REQ-035 SHALL drive busy=1 in LOAD and DONE.
REQ-036 SHALL size the counters as row $clog2(SYS_ROW) bits and tile TILE_CNT_WIDTH bits, and SHALL compute the address arithmetic in ADDR_WIDTH+TILE_CNT_WIDTH bits before truncation.

Reset
REQ-037 SHALL, when rstn=0 at an edge, go to IDLE and clear to 0: row, tile, wr_en, wr_addr, wr_data, in_ready, busy, done and err.
REQ-038 SHALL let reset abort a load in progress with no further writes and no done pulse.

Verification
REQ-039 Forward load (SYS_ROW=4, base=0x10, tiles=2, rev=0, mask=all 1s, in_valid held high) -> wr_addr 0x10..0x17 on consecutive cycles, done on the 0x17 write cycle.
REQ-040 Reversed load (SYS_ROW=4, base=0, tiles=1, rev=1) -> wr_addr 3,2,1,0; the data order matches the input order.
REQ-041 Stalled load (in_valid toggling 1,0,0,1) -> wr_en=0 in the stall cycles, no address skipped, and the total number of writes equals 4*tiles.
REQ-042 Wrap-around (ADDR_WIDTH=4, base=0xE, SYS_ROW=4, tiles=1) -> wr_addr E,F,0,1.
REQ-043 Error cases (cfg_num_tiles=0; in_valid while IDLE; cfg_start during LOAD) -> err=1, no write, the current load is unaffected.
REQ-044 Reset mid-load (rstn=0 after 2 rows) -> all outputs 0 the next cycle, no done, and a new cfg_start loads from row 0.
